// File: rtl/down_counter_timer_pkg.sv
// down_counter_pkg: shared types and encodings for down_counter_timer.
//   state_t  : FSM state (IDLE, RUN, DONE), 2-bit encoded
//   ST_*     : fixed state encodings, usable where a plain constant is needed
package down_counter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/down_counter_timer_if.sv
// down_counter_timer_if: control/status bundle of the down-counter timer.
//   load, load_val, start, pause : commands from the controlling FSM
//   q, busy, tc, done            : registered timer status
//   master : controller side (drives commands, observes status)
//   slave  : timer side
interface down_counter_timer_if #(
  parameter int WIDTH = 4
);

  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             tc;
  logic             done;

  modport master (
    output load, load_val, start, pause,
    input  q, busy, tc, done
  );

  modport slave (
    input  load, load_val, start, pause,
    output q, busy, tc, done
  );

endinterface

// File: rtl/down_counter_timer_prescaler.sv
// dct_prescaler: divides enabled clock cycles by PRESCALE.
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset
//   clr   : synchronous clear of the phase counter (wins over en)
//   en    : advance the phase counter this cycle
//   tick  : high in the enabled cycle that completes a PRESCALE-cycle period
// With PRESCALE=1 there is no counter and tick follows en directly.
module dct_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  if (PRESCALE == 1) begin : g_direct
    assign tick = en;
    // Clock, reset and clear have no function without a counter.
    logic unused_ports;
    assign unused_ports = clk ^ rst ^ clr;
  end else begin : g_count
    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt <= '0;
      end else if (clr) begin
        cnt <= '0;
      end else if (en) begin
        cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
    end

    assign tick = en && !clr && (cnt == LAST);
  end

endmodule

// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down-counter / timeout generator.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : down_counter_timer_if.slave (load, load_val, start, pause in;
//         q, busy, tc, done out, all registered)
// Parameters: WIDTH (counter width), PRESCALE (clk cycles per decrement).
// Build option: define AUTO_RELOAD_EN to reload q from the last loaded value
// on terminal count and keep running (periodic tc) instead of stopping.
module down_counter_timer
  import down_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input logic             clk,
  input logic             rst,
  down_counter_timer_if.slave bus
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_r, q_nxt;
  logic [WIDTH-1:0] reload_reg, reload_nxt;
  logic             tc_r, tc_nxt;
  logic             busy_r, done_r;
  logic             arm_r, arm_nxt;
  logic             tick, pre_en, pre_clr;

  // The first RUN cycle only arms the prescaler, so with PRESCALE=1 the
  // first decrement lands two edges after start is sampled and terminal
  // count comes N*PRESCALE cycles after that arming edge.
  assign pre_en  = (state == RUN) && arm_r && !bus.pause;
  assign pre_clr = bus.load || (state != RUN);

  dct_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .en   (pre_en),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      q_r        <= '0;
      reload_reg <= '0;
      tc_r       <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      arm_r      <= 1'b0;
    end else begin
      state      <= state_nxt;
      q_r        <= q_nxt;
      reload_reg <= reload_nxt;
      tc_r       <= tc_nxt;
      busy_r     <= (state_nxt == RUN);
      done_r     <= (state_nxt == DONE);
      arm_r      <= arm_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    q_nxt      = q_r;
    reload_nxt = reload_reg;
    tc_nxt     = 1'b0;
    if (bus.load) begin
      q_nxt      = bus.load_val;
      reload_nxt = bus.load_val;
      state_nxt  = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (q_r != '0) begin
              state_nxt = RUN;
            end else begin
              state_nxt = DONE;
              tc_nxt    = 1'b1;
            end
          end
        end
        RUN: begin
          if (tick) begin
            if (q_r > WIDTH'(1)) begin
              q_nxt = q_r - WIDTH'(1);
            end else begin
              // Terminal tick; a zero count never decrements further.
              tc_nxt = (q_r == WIDTH'(1));
`ifdef AUTO_RELOAD_EN
              if (reload_reg != '0) begin
                q_nxt = reload_reg;
              end else begin
                q_nxt     = '0;
                state_nxt = DONE;
              end
`else
              q_nxt     = '0;
              state_nxt = DONE;
`endif
            end
          end
        end
        DONE: begin
          state_nxt = DONE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
    arm_nxt = (state == RUN) && (state_nxt == RUN);
  end

`ifndef AUTO_RELOAD_EN
  // The reload value only feeds the auto-reload path.
  logic unused_reload;
  assign unused_reload = ^reload_reg;
`endif

  assign bus.q    = q_r;
  assign bus.busy = busy_r;
  assign bus.tc   = tc_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_down_counter_timer.sv
module tb_down_counter_timer;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  down_counter_timer_if #(.WIDTH(W)) bus1 ();
  down_counter_timer_if #(.WIDTH(W)) bus3 ();

  down_counter_timer #(.WIDTH(W), .PRESCALE(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  down_counter_timer #(.WIDTH(W), .PRESCALE(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  typedef struct {
    string          tag;
    int             dut;
    logic           ld;
    logic [W-1:0]   val;
    logic           st;
    logic           pa;
    logic [W-1:0]   q;
    logic           busy;
    logic           tc;
    logic           done;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  task automatic add(input string tag, input int d, input logic ld,
                     input logic [W-1:0] val, input logic st, input logic pa,
                     input logic [W-1:0] q, input logic b, input logic t,
                     input logic dn);
    vec_t v;
    v.tag = tag; v.dut = d; v.ld = ld; v.val = val; v.st = st; v.pa = pa;
    v.q = q; v.busy = b; v.tc = t; v.done = dn;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic ld, input logic [W-1:0] val,
                       input logic st, input logic pa);
    bus1.load = 1'b0; bus1.load_val = '0; bus1.start = 1'b0; bus1.pause = 1'b0;
    bus3.load = 1'b0; bus3.load_val = '0; bus3.start = 1'b0; bus3.pause = 1'b0;
    if (d == 1) begin
      bus1.load = ld; bus1.load_val = val; bus1.start = st; bus1.pause = pa;
    end else begin
      bus3.load = ld; bus3.load_val = val; bus3.start = st; bus3.pause = pa;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int d, input logic [W-1:0] q,
                           input logic b, input logic t, input logic dn);
    if (d == 1) begin
      check({tag, ".q"},    32'(bus1.q),    32'(q));
      check({tag, ".busy"}, 32'(bus1.busy), 32'(b));
      check({tag, ".tc"},   32'(bus1.tc),   32'(t));
      check({tag, ".done"}, 32'(bus1.done), 32'(dn));
    end else begin
      check({tag, ".q"},    32'(bus3.q),    32'(q));
      check({tag, ".busy"}, 32'(bus3.busy), 32'(b));
      check({tag, ".tc"},   32'(bus3.tc),   32'(t));
      check({tag, ".done"}, 32'(bus3.done), 32'(dn));
    end
  endtask

  initial begin
    // tag, dut, load, val, start, pause, exp q, busy, tc, done
    add("ld_st",      1, 1, 7, 1, 0, 7, 0, 0, 0);
    add("ld_st_hold", 1, 0, 0, 0, 0, 7, 0, 0, 0);
    add("ld0",        1, 1, 0, 0, 0, 0, 0, 0, 0);
    add("st0",        1, 0, 0, 1, 0, 0, 0, 1, 1);
    add("st0_after",  1, 0, 0, 0, 0, 0, 0, 0, 1);
    add("done_st",    1, 0, 0, 1, 0, 0, 0, 0, 1);
    add("ld4",        1, 1, 4, 0, 0, 4, 0, 0, 0);
    add("run4",       1, 0, 0, 1, 0, 4, 1, 0, 0);
    add("arm4",       1, 0, 0, 0, 0, 4, 1, 0, 0);
    add("dec3",       1, 0, 0, 0, 0, 3, 1, 0, 0);
    add("ld9_run",    1, 1, 9, 0, 0, 9, 0, 0, 0);
    add("idle9",      1, 0, 0, 0, 0, 9, 0, 0, 0);
`ifndef AUTO_RELOAD_EN
    add("os_ld5",     1, 1, 5, 0, 0, 5, 0, 0, 0);
    add("os_st",      1, 0, 0, 1, 0, 5, 1, 0, 0);
    add("os_arm",     1, 0, 0, 0, 0, 5, 1, 0, 0);
    add("os_q4",      1, 0, 0, 0, 0, 4, 1, 0, 0);
    add("os_q3",      1, 0, 0, 0, 0, 3, 1, 0, 0);
    add("os_q2",      1, 0, 0, 0, 0, 2, 1, 0, 0);
    add("os_q1",      1, 0, 0, 0, 0, 1, 1, 0, 0);
    add("os_tc",      1, 0, 0, 0, 0, 0, 0, 1, 1);
    add("os_hold",    1, 0, 0, 0, 0, 0, 0, 0, 1);
    add("os_st_done", 1, 0, 0, 1, 0, 0, 0, 0, 1);
    add("pz_ld6",     1, 1, 6, 0, 0, 6, 0, 0, 0);
    add("pz_st",      1, 0, 0, 1, 0, 6, 1, 0, 0);
    add("pz_arm",     1, 0, 0, 0, 0, 6, 1, 0, 0);
    add("pz_q5",      1, 0, 0, 0, 0, 5, 1, 0, 0);
    add("pz_q4",      1, 0, 0, 0, 0, 4, 1, 0, 0);
    add("pz_hold1",   1, 0, 0, 0, 1, 4, 1, 0, 0);
    add("pz_hold2",   1, 0, 0, 0, 1, 4, 1, 0, 0);
    add("pz_hold3",   1, 0, 0, 0, 1, 4, 1, 0, 0);
    add("pz_q3",      1, 0, 0, 0, 0, 3, 1, 0, 0);
    add("pz_q2",      1, 0, 0, 0, 0, 2, 1, 0, 0);
    add("pz_q1",      1, 0, 0, 0, 0, 1, 1, 0, 0);
    add("pz_tc",      1, 0, 0, 0, 0, 0, 0, 1, 1);
    add("ps_ld2",     3, 1, 2, 0, 0, 2, 0, 0, 0);
    add("ps_st",      3, 0, 0, 1, 0, 2, 1, 0, 0);
    add("ps_c1",      3, 0, 0, 0, 0, 2, 1, 0, 0);
    add("ps_c2",      3, 0, 0, 0, 0, 2, 1, 0, 0);
    add("ps_c3",      3, 0, 0, 0, 0, 2, 1, 0, 0);
    add("ps_c4",      3, 0, 0, 0, 0, 1, 1, 0, 0);
    add("ps_c5",      3, 0, 0, 0, 0, 1, 1, 0, 0);
    add("ps_c6",      3, 0, 0, 0, 0, 1, 1, 0, 0);
    add("ps_tc",      3, 0, 0, 0, 0, 0, 0, 1, 1);
    add("ps_hold",    3, 0, 0, 0, 0, 0, 0, 0, 1);
`else
    add("ar_ld3",     1, 1, 3, 0, 0, 3, 0, 0, 0);
    add("ar_st",      1, 0, 0, 1, 0, 3, 1, 0, 0);
    add("ar_arm",     1, 0, 0, 0, 0, 3, 1, 0, 0);
    for (int p = 0; p < 4; p++) begin
      add("ar_q2",    1, 0, 0, 0, 0, 2, 1, 0, 0);
      add("ar_q1",    1, 0, 0, 0, 0, 1, 1, 0, 0);
      add("ar_tc",    1, 0, 0, 0, 0, 3, 1, 1, 0);
    end
    add("ar_ld0",     1, 1, 0, 0, 0, 0, 0, 0, 0);
    add("ar_idle",    1, 0, 0, 0, 0, 0, 0, 0, 0);
`endif

    drive(1, 0, '0, 0, 0);
    rst = 1'b1;
    #1 rst = 1'b0;
    #10;
    check_out("rst1", 1, 0, 0, 0, 0);
    check_out("rst3", 3, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].dut, vecs[i].ld, vecs[i].val, vecs[i].st, vecs[i].pa);
      step();
      check_out(vecs[i].tag, vecs[i].dut, vecs[i].q, vecs[i].busy,
                vecs[i].tc, vecs[i].done);
    end

    // Asynchronous reset in the middle of a count.
    drive(1, 1, 5, 0, 0);
    step();
    drive(1, 0, '0, 1, 0);
    step();
    drive(1, 0, '0, 0, 0);
    step();
    step();
    step();
    check_out("mid_run", 1, 3, 1, 0, 0);
    #3 rst = 1'b0;
    #1;
    check_out("async_rst", 1, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      check("post_rst.tc", 32'(bus1.tc), 32'd0);
    end
    check_out("post_rst", 1, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
